// File: rtl/game_tick_gen.sv
// game_tick_gen: level-scaled game step pulse generator with run/pause/halt control and optional auto speed-up.
module game_tick_gen #(
  parameter int CNT_W         = 26,
  parameter int BASE_CYCLES   = 50000000,
  parameter int STEP_CYCLES   = 6250000,
  parameter int MIN_CYCLES    = 6250000,
  parameter int LVL_W         = 3,
  parameter int AUTO          = 0,
  parameter int TICKS_PER_LVL = 16,
  parameter int TCNT_W        = 16
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              gameOver,
  input  logic [LVL_W-1:0]  level_in,
  output logic              tick,
  output logic [LVL_W-1:0]  level,
  output logic [TCNT_W-1:0] tick_count,
  output logic              running
);
  localparam int PW = CNT_W + LVL_W;
  localparam int AW = TICKS_PER_LVL > 1 ? $clog2(TICKS_PER_LVL) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, HALT = 2'd3;
  localparam logic [LVL_W-1:0] LVL_MAX = '1;
  logic [1:0] st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [LVL_W-1:0] level_q, level_d, lvl_nxt;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [AW-1:0] auto_q, auto_d;
  logic tick_q, enter, adv, wrap, auto_hit;
  // Underflow and anything below the floor both clamp to MIN_CYCLES.
  function automatic logic [CNT_W-1:0] period_of(input logic [LVL_W-1:0] l);
    logic [PW-1:0] prod, diff;
    prod = PW'(l) * PW'(STEP_CYCLES);
    diff = PW'(BASE_CYCLES) - prod;
    return (prod > PW'(BASE_CYCLES) || diff < PW'(MIN_CYCLES)) ? CNT_W'(MIN_CYCLES) : CNT_W'(diff);
  endfunction
  always_comb begin
    enter    = start && !gameOver && (st_q == IDLE || st_q == HALT);
    adv      = !gameOver && !pause && (st_q == RUN || st_q == PAUSE);
    wrap     = adv && cnt_q == period_q - CNT_W'(1);
    auto_hit = auto_q == AW'(TICKS_PER_LVL - 1);
    st_d     = gameOver ? HALT : enter ? RUN : (st_q == RUN && pause) ? PAUSE :
               (st_q == PAUSE && !pause) ? RUN : st_q;
    lvl_nxt  = AUTO == 0 ? level_in : enter ? '0 :
               (auto_hit && level_q != LVL_MAX) ? level_q + LVL_W'(1) : level_q;
    level_d  = (enter || wrap) ? lvl_nxt : level_q;
    period_d = (enter || wrap) ? period_of(lvl_nxt) : period_q;
    cnt_d    = (enter || gameOver || wrap) ? '0 : adv ? cnt_q + CNT_W'(1) : cnt_q;
    tcnt_d   = enter ? '0 : wrap ? tcnt_q + TCNT_W'(1) : tcnt_q;
    auto_d   = enter ? '0 : (wrap && AUTO != 0) ? (auto_hit ? '0 : auto_q + AW'(1)) : auto_q;
  end
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      period_q <= CNT_W'(BASE_CYCLES);
      level_q  <= '0;
      tcnt_q   <= '0;
      auto_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      level_q  <= level_d;
      tcnt_q   <= tcnt_d;
      auto_q   <= auto_d;
      tick_q   <= wrap;
    end
  end
  assign tick       = tick_q;
  assign level      = level_q;
  assign tick_count = tcnt_q;
  assign running    = st_q == RUN;
endmodule

// File: doc/game_tick_gen.md
GAME_TICK_GEN -- requirements
Module: game_tick_gen

Interface
REQ-001 Parameter CNT_W, 26, width of the period counter.
REQ-002 Parameter BASE_CYCLES, 50000000, tick period in clk50 cycles at level 0.
REQ-003 Parameter STEP_CYCLES, 6250000, period reduction per level.
REQ-004 Parameter MIN_CYCLES, 6250000, floor on the tick period; legal range is 2..BASE_CYCLES.
REQ-005 Parameter LVL_W, 3, width of the speed level.
REQ-006 Parameter AUTO, 0, level source: 0 = external level_in, 1 = internal auto-speedup.
REQ-007 Parameter TICKS_PER_LVL, 16, ticks per level increment when AUTO=1; must be at least 1.
REQ-008 Parameter TCNT_W, 16, width of tick_count.
REQ-009 clk50  in  1  system clock; the block has one clock.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 start  in  1  level-sensitive request to begin or restart the game.
REQ-012 pause  in  1  level-sensitive freeze request.
REQ-013 gameOver  in  1  level-sensitive halt request.
REQ-014 level_in  in  LVL_W  external speed level, used when AUTO=0.
REQ-015 tick  out  1  registered one-cycle game-step pulse.
REQ-016 level  out  LVL_W  speed level currently in effect.
REQ-017 tick_count  out  TCNT_W  number of ticks since the last start; wraps modulo 2^TCNT_W.
REQ-018 running  out  1  high only in state RUN.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN, PAUSE and HALT; gameOver takes priority over every other transition.
REQ-020 IDLE->RUN on start; RUN->PAUSE on pause; PAUSE->RUN on !pause; any state->HALT on gameOver; HALT->RUN on start && !gameOver.
REQ-021 Each entry to RUN from IDLE or HALT SHALL clear the counter and tick_count, set level to 0 (AUTO=1) or level_in (AUTO=0), and latch period_q.
REQ-022 Period = BASE_CYCLES - level*STEP_CYCLES, computed at CNT_W+LVL_W bits; any result below MIN_CYCLES, or an underflow, SHALL give MIN_CYCLES.
REQ-023 period_q SHALL be relatched only at a tick or on entry to RUN; a change to level_in mid-period takes effect from the following period.
REQ-024 In RUN the counter SHALL increment each cycle; at counter==period_q-1 it SHALL wrap to 0 and tick SHALL be 1 in the next cycle.
REQ-025 If RUN is entered at edge 0, ticks SHALL occur in cycles P, 2P, 3P and so on, where P is period_q.
REQ-026 tick_count SHALL increment in the same cycle that tick is high.
REQ-027 In PAUSE the counter, tick_count and level SHALL hold, and tick SHALL be 0; on return to RUN the count resumes with no lost or extra cycles.
REQ-028 pause asserted in the same cycle as counter==period_q-1 SHALL suppress that wrap; the wrap occurs after resume.
REQ-029 In HALT and IDLE, tick SHALL be 0, the counter SHALL hold at 0, and level and tick_count SHALL hold their last values.
REQ-030 When AUTO=1, an internal tick counter SHALL increment level after every TICKS_PER_LVL ticks, saturating at 2^LVL_W-1; the new level applies to the next period.
REQ-031 When AUTO=0, level SHALL equal the level_in value sampled at the last period_q latch.
REQ-032 start asserted while in RUN or PAUSE SHALL be ignored.

Reset
REQ-033 Reset SHALL asynchronously force the state to IDLE and counter, tick, tick_count, level, running and the auto counter to 0.
REQ-034 Reset SHALL force period_q to BASE_CYCLES.
REQ-035 Reset asserted mid-period SHALL discard the partial period with no tick.

Verification
Bench parameters: BASE_CYCLES=10, STEP_CYCLES=2, MIN_CYCLES=4, LVL_W=3, TICKS_PER_LVL=2.
REQ-036 AUTO=0, level_in=0, start pulse enters RUN at edge 0 -> tick high in cycles 10, 20 and 30; tick_count reads 1, 2, 3.
REQ-037 level_in changes 0->2 at cycle 13 -> next tick at cycle 20, then 26, 32 (period 6).
REQ-038 level_in=5 (10-10=0 < MIN) -> period 4; level_in=7 -> period 4.
REQ-039 pause high for cycles 15-19 -> ticks at 25 and 35; pause coinciding with counter==9 produces no tick until resume.
REQ-040 AUTO=1 -> tick intervals 10,10,8,8,6,6,4,4,4,...; level saturates at 7 with period held at 4.
REQ-041 gameOver at cycle 14 -> HALT, tick=0, running=0, tick_count=1; start at cycle 30 -> tick_count=0 and first tick at cycle 40 (10 cycles after RUN entry).
REQ-042 start and gameOver asserted together -> remains in HALT.
REQ-043 reset at cycle 7 -> all outputs 0 immediately, with no clock edge needed.
